fifo_word_packer: RTL and testbench
===================================

// Module: fifo_word_packer
// PURPOSE
//  Downstream consumer of the 4-bit push/pop nibble FIFO. Drains nibbles while the FIFO is non-empty and packs
//  NIBBLES of them into one word. Presents each completed word on a valid/ready handshake to the next stage.
//  Exists so the narrow FIFO can feed word-wide logic without stalling the FIFO's producer.
// PARAMETERS
//  DW       4   width of one FIFO entry (nibble) in bits
//  NIBBLES  4   entries packed per output word; word width = DW*NIBBLES (16 by default)
// PORTS
//  clk         in   1        system clock, all state on rising edge
//  reset       in   1        synchronous, active-high reset
//  fifo_empty  in   1        upstream FIFO has no entries
//  fifo_data   in   DW       upstream FIFO head entry (show-ahead, valid while !fifo_empty)
//  fifo_pop    out  1        pop request to upstream FIFO, one entry per asserted cycle
//  flush       in   1        discard partially packed word, return to FILL
//  word_out    out  DW*NIB   packed word, first-popped nibble in bits [DW-1:0]
//  word_valid  out  1        word_out holds a complete word
//  word_ready  in   1        downstream accepts word_out this cycle
//  nib_cnt     out  3        nibbles captured into the current word (0..NIBBLES)
//  word_cnt    out  8        completed words accepted downstream, wraps 255->0
// BEHAVIOUR
//  Reset: state=FILL, word_out=0, word_valid=0, fifo_pop=0, nib_cnt=0, word_cnt=0.
//  FSM, 2 states:
//   FILL: fifo_pop = !fifo_empty (combinational, only in FILL). On a pop cycle:
//         word_out <= {fifo_data, word_out[MSB:DW]} (right-shift in at top); nib_cnt <= nib_cnt+1.
//         When the pop makes nib_cnt reach NIBBLES -> HOLD, word_valid <= 1 the next cycle.
//   HOLD: fifo_pop=0, word_out frozen, word_valid=1. When word_ready=1: word_valid <= 0,
//         nib_cnt <= 0, word_cnt <= word_cnt+1 (mod 256), -> FILL.
//  Latency: first nibble popped to word_valid = NIBBLES cycles minimum (no gaps); 1 bubble cycle per word
//   (HOLD->FILL), so sustained throughput = 1 word per NIBBLES+1 cycles.
//  Empty: fifo_empty=1 in FILL -> no pop, no shift, nib_cnt holds; packing resumes on the next non-empty cycle.
//  Never pops in HOLD, so the upstream FIFO absorbs backpressure; a full upstream FIFO is not this block's concern.
//  word_ready while word_valid=0: ignored. word_valid does not drop without word_ready (no retraction).
//  flush=1 (any state): nib_cnt <= 0, word_valid <= 0, word_out <= 0, -> FILL; fifo_pop forced 0 that cycle;
//   word_cnt unchanged. flush has priority over word_ready and pop.
//  reset has priority over flush; reset mid-word discards the partial word; no popped data is recovered.
//  nib_cnt is 3 bits and must cover NIBBLES; word_cnt wraps silently.
// TESTING
//  1 Reset then 4 nibbles 1,2,3,4 available, word_ready=1 -> 4 pops, word_out=16'h4321, word_valid 1 cycle, word_cnt=1.
//  2 Nibbles A,B then fifo_empty for 5 cycles then C,D -> no pops while empty, nib_cnt holds 2, final word 16'hDCBA.
//  3 Complete word, word_ready=0 for 10 cycles -> word_valid stays 1, word_out stable, fifo_pop=0 throughout; accepted on ready.
//  4 Two nibbles packed then flush=1 -> nib_cnt=0, word_valid=0, no pop that cycle; next 4 nibbles 5,6,7,8 -> 16'h8765.
//  5 Continuous non-empty FIFO, ready=1, 256 words -> word_cnt wraps to 0; pop duty = 4 of every 5 cycles.
//  6 Reset asserted in HOLD with word_valid=1 -> next cycle word_valid=0, word_out=0, state FILL, counters 0.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Drains a show-ahead nibble FIFO and packs NIBBLES entries into one word,
// presented downstream on a valid/ready handshake.
module fifo_word_packer #(
  parameter int DW      = 4,
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DW-1:0]         fifo_data,
  output logic                  fifo_pop,
  input  logic                  flush,
  output logic [DW*NIBBLES-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [2:0]            nib_cnt,
  output logic [7:0]            word_cnt
);
  localparam int WW = DW * NIBBLES;

  typedef enum logic {FILL, HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [WW-1:0]    r_word;
  logic [2:0]       r_nib_cnt;
  logic [7:0]       r_word_cnt;
  logic             w_pop;
  logic             w_accept;

  always_ff @(posedge clk) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_state_nxt;
  end

  // flush wins over both the pop and the downstream accept
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      FILL: begin
        if (!flush && !reset && !fifo_empty) begin
          w_pop = 1'b1;
          if (r_nib_cnt == 3'(NIBBLES - 1)) w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!flush && word_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
    if (flush) w_state_nxt = FILL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word     <= '0;
      r_nib_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (flush) begin
      r_word    <= '0;
      r_nib_cnt <= '0;
    end else if (w_pop) begin
      r_word    <= {fifo_data, r_word[WW-1:DW]};
      r_nib_cnt <= r_nib_cnt + 3'd1;
    end else if (w_accept) begin
      r_nib_cnt  <= '0;
      r_word_cnt <= r_word_cnt + 8'd1;
    end
  end

  assign fifo_pop   = w_pop;
  assign word_out   = r_word;
  assign word_valid = (r_state == HOLD);
  assign nib_cnt    = r_nib_cnt;
  assign word_cnt   = r_word_cnt;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed scenarios plus random traffic against a queue-based packing model.
module tb_fifo_word_packer;
  localparam int DW = 4;
  localparam int N  = 4;
  localparam int WW = DW * N;

  logic          clk = 1'b0;
  logic          reset, fifo_empty, fifo_pop, flush, word_valid, word_ready;
  logic [DW-1:0] fifo_data;
  logic [WW-1:0] word_out;
  logic [2:0]    nib_cnt;
  logic [7:0]    word_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;

  // model: nibbles popped since the word register was last cleared, plus counts
  logic [DW-1:0] m_hist[$];
  int            m_n    = 0;
  int            m_wcnt = 0;

  fifo_word_packer #(.DW(DW), .NIBBLES(N)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .flush(flush), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .nib_cnt(nib_cnt),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // newest popped nibble sits in the top slot, older ones below it
  function automatic logic [WW-1:0] m_word();
    logic [WW-1:0] w = '0;
    int k = m_hist.size();
    for (int j = 0; j < k; j++) w[(N - k + j)*DW +: DW] = m_hist[j];
    return w;
  endfunction

  task automatic cyc(input bit rst, input bit fl, input bit emp,
                     input logic [DW-1:0] d, input bit rdy);
    bit exp_pop;
    reset = rst; flush = fl; fifo_empty = emp; fifo_data = d; word_ready = rdy;
    #1;
    exp_pop = !rst && !fl && !emp && (m_n < N);
    chk("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
    if (fifo_pop) pops++;
    @(posedge clk);
    if (rst) begin
      m_hist.delete(); m_n = 0; m_wcnt = 0;
    end else if (fl) begin
      m_hist.delete(); m_n = 0;
    end else if (exp_pop) begin
      m_hist.push_back(d);
      if (m_hist.size() > N) void'(m_hist.pop_front());
      m_n++;
    end else if (m_n == N && rdy) begin
      m_n = 0; m_wcnt = (m_wcnt + 1) % 256;
    end
    @(negedge clk);
    chk("word_valid", 32'(word_valid), 32'(m_n == N));
    chk("word_out",   32'(word_out),   32'(m_word()));
    chk("nib_cnt",    32'(nib_cnt),    32'(m_n));
    chk("word_cnt",   32'(word_cnt),   32'(m_wcnt));
  endtask

  initial begin
    logic [WW-1:0] held;
    reset = 1'b1; flush = 1'b0; fifo_empty = 1'b1; fifo_data = '0; word_ready = 1'b0;
    @(negedge clk);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 4'h9, 1);
    chk("rst_state", {word_out, 3'(nib_cnt), 8'(word_cnt), 1'(word_valid)}, '0);

    // 1: nibbles 1..4 -> 16'h4321, valid for one cycle
    for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 4'(i), 1);
    chk("t1_word", 32'(word_out), 32'h4321);
    chk("t1_valid", 32'(word_valid), 32'd1);
    cyc(0, 0, 1, 0, 1);
    chk("t1_drop", 32'(word_valid), 32'd0);
    chk("t1_wcnt", 32'(word_cnt), 32'd1);

    // 2: A,B, empty gap, C,D
    cyc(0, 0, 0, 4'hA, 1); cyc(0, 0, 0, 4'hB, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 4'hF, 1);
    chk("t2_hold_nib", 32'(nib_cnt), 32'd2);
    cyc(0, 0, 0, 4'hC, 0); cyc(0, 0, 0, 4'hD, 0);
    chk("t2_word", 32'(word_out), 32'hDCBA);

    // 3: backpressure for 10 cycles with data available
    held = word_out;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 4'(i), 0);
    chk("t3_stable", 32'(word_out), 32'(held));
    chk("t3_valid", 32'(word_valid), 32'd1);
    cyc(0, 0, 0, 4'h0, 1);
    chk("t3_acc", 32'(word_valid), 32'd0);

    // 4: flush after two nibbles, then 5..8
    cyc(0, 0, 0, 4'h1, 1); cyc(0, 0, 0, 4'h2, 1);
    cyc(0, 1, 0, 4'h3, 1);
    chk("t4_nib", 32'(nib_cnt), 32'd0);
    for (int i = 5; i <= 8; i++) cyc(0, 0, 0, 4'(i), 1);
    chk("t4_word", 32'(word_out), 32'h8765);
    cyc(0, 0, 1, 0, 1);

    // 5: 256 back-to-back words from a fresh reset
    cyc(1, 0, 1, 0, 0);
    pops = 0;
    for (int i = 0; i < 256 * (N + 1); i++) cyc(0, 0, 0, 4'($urandom), 1);
    chk("t5_wrap", 32'(word_cnt), 32'd0);
    chk("t5_duty", 32'(pops), 32'(256 * N));

    // 6: reset while a word is held
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 4'($urandom), 0);
    chk("t6_valid_pre", 32'(word_valid), 32'd1);
    cyc(1, 0, 0, 4'h5, 1);
    chk("t6_after", {word_out, 3'(nib_cnt), 8'(word_cnt), 1'(word_valid)}, '0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 2) == 0, 4'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
